// File: rtl/reflet_rect_fill_if.sv
// Command and pixel-write signals of the rectangle fill engine.
// The outline input exists only when RECT_OUTLINE_EN is defined.
interface reflet_rect_fill_if #(
  parameter int h_size      = 640,
  parameter int v_line      = 480,
  parameter int color_depth = 8
);
  localparam int XW = $clog2(h_size);
  localparam int YW = $clog2(v_line);

  logic                   start;
  logic [XW-1:0]          x0;
  logic [XW-1:0]          x1;
  logic [YW-1:0]          y0;
  logic [YW-1:0]          y1;
  logic [color_depth-1:0] R_in;
  logic [color_depth-1:0] G_in;
  logic [color_depth-1:0] B_in;
`ifdef RECT_OUTLINE_EN
  logic                   outline;
`endif
  logic                   busy;
  logic                   done;
  logic                   write_en;
  logic [XW-1:0]          h_pixel;
  logic [YW-1:0]          v_pixel;
  logic [color_depth-1:0] R_out;
  logic [color_depth-1:0] G_out;
  logic [color_depth-1:0] B_out;

  modport master (
`ifdef RECT_OUTLINE_EN
    output outline,
`endif
    output start, x0, x1, y0, y1, R_in, G_in, B_in,
    input  busy, done, write_en, h_pixel, v_pixel, R_out, G_out, B_out
  );

  modport slave (
`ifdef RECT_OUTLINE_EN
    input  outline,
`endif
    input  start, x0, x1, y0, y1, R_in, G_in, B_in,
    output busy, done, write_en, h_pixel, v_pixel, R_out, G_out, B_out
  );
endinterface

// File: rtl/reflet_rect_fill.sv
// Rectangle fill engine: one frame-buffer pixel write per cycle in raster order.
// Optional border-only mode is compiled in with RECT_OUTLINE_EN.
module reflet_rect_fill #(
  parameter int h_size      = 640,
  parameter int v_line      = 480,
  parameter int color_depth = 8
) (
  input  logic               clk,
  input  logic               reset,
  reflet_rect_fill_if.slave  bus
);
  localparam int XW = $clog2(h_size);
  localparam int YW = $clog2(v_line);
  localparam int CW = color_depth;
  localparam logic [XW-1:0] X_LIM = XW'(h_size - 1);
  localparam logic [YW-1:0] Y_LIM = YW'(v_line - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_r, state_s;
  logic [XW-1:0]   xmin_r, xmax_r, xmin_s, xmax_s;
  logic [YW-1:0]   ymin_r, ymax_r, ymin_s, ymax_s;
  logic [XW-1:0]   h_pixel_r, h_pixel_s;
  logic [YW-1:0]   v_pixel_r, v_pixel_s;
  logic [CW-1:0]   r_out_r, g_out_r, b_out_r, r_out_s, g_out_s, b_out_s;
  logic            write_en_r, busy_r, done_r, write_en_s, busy_s, done_s;
  logic            outline_r, outline_s;
  logic [XW-1:0]   cx0_s, cx1_s;
  logic [YW-1:0]   cy0_s, cy1_s;
  logic            interior_row_s;

  function automatic logic [XW-1:0] clamp_x(input logic [XW-1:0] v);
    if (v > X_LIM) clamp_x = X_LIM;
    else           clamp_x = v;
  endfunction

  function automatic logic [YW-1:0] clamp_y(input logic [YW-1:0] v);
    if (v > Y_LIM) clamp_y = Y_LIM;
    else           clamp_y = v;
  endfunction

  // Next-state and next-output computation; the output registers double as the x/y counters.
  always_comb begin
    state_s    = state_r;
    xmin_s     = xmin_r;
    xmax_s     = xmax_r;
    ymin_s     = ymin_r;
    ymax_s     = ymax_r;
    h_pixel_s  = h_pixel_r;
    v_pixel_s  = v_pixel_r;
    r_out_s    = r_out_r;
    g_out_s    = g_out_r;
    b_out_s    = b_out_r;
    write_en_s = 1'b0;
    busy_s     = 1'b0;
    done_s     = 1'b0;
    outline_s  = outline_r;
    cx0_s      = clamp_x(bus.x0);
    cx1_s      = clamp_x(bus.x1);
    cy0_s      = clamp_y(bus.y0);
    cy1_s      = clamp_y(bus.y1);
    interior_row_s = (v_pixel_r != ymin_r) && (v_pixel_r != ymax_r);

    case (state_r)
      IDLE: begin
        if (bus.start) begin
          xmin_s     = (cx0_s < cx1_s) ? cx0_s : cx1_s;
          xmax_s     = (cx0_s < cx1_s) ? cx1_s : cx0_s;
          ymin_s     = (cy0_s < cy1_s) ? cy0_s : cy1_s;
          ymax_s     = (cy0_s < cy1_s) ? cy1_s : cy0_s;
          h_pixel_s  = xmin_s;
          v_pixel_s  = ymin_s;
          r_out_s    = bus.R_in;
          g_out_s    = bus.G_in;
          b_out_s    = bus.B_in;
`ifdef RECT_OUTLINE_EN
          outline_s  = bus.outline;
`else
          outline_s  = 1'b0;
`endif
          write_en_s = 1'b1;
          busy_s     = 1'b1;
          state_s    = FILL;
        end else begin
          state_s    = IDLE;
        end
      end
      FILL: begin
        if ((h_pixel_r == xmax_r) && (v_pixel_r == ymax_r)) begin
          done_s     = 1'b1;
          state_s    = DONE;
        end else begin
          write_en_s = 1'b1;
          busy_s     = 1'b1;
          if (h_pixel_r == xmax_r) begin
            h_pixel_s = xmin_r;
            v_pixel_s = v_pixel_r + YW'(1);
          end else if (outline_r && interior_row_s && (h_pixel_r == xmin_r)) begin
            // Border-only rows skip the interior span in one step.
            h_pixel_s = xmax_r;
          end else begin
            h_pixel_s = h_pixel_r + XW'(1);
          end
        end
      end
      DONE: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State and registered-output update with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r    <= IDLE;
      xmin_r     <= '0;
      xmax_r     <= '0;
      ymin_r     <= '0;
      ymax_r     <= '0;
      h_pixel_r  <= '0;
      v_pixel_r  <= '0;
      r_out_r    <= '0;
      g_out_r    <= '0;
      b_out_r    <= '0;
      write_en_r <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      outline_r  <= 1'b0;
    end else begin
      state_r    <= state_s;
      xmin_r     <= xmin_s;
      xmax_r     <= xmax_s;
      ymin_r     <= ymin_s;
      ymax_r     <= ymax_s;
      h_pixel_r  <= h_pixel_s;
      v_pixel_r  <= v_pixel_s;
      r_out_r    <= r_out_s;
      g_out_r    <= g_out_s;
      b_out_r    <= b_out_s;
      write_en_r <= write_en_s;
      busy_r     <= busy_s;
      done_r     <= done_s;
      outline_r  <= outline_s;
    end
  end

  assign bus.write_en = write_en_r;
  assign bus.busy     = busy_r;
  assign bus.done     = done_r;
  assign bus.h_pixel  = h_pixel_r;
  assign bus.v_pixel  = v_pixel_r;
  assign bus.R_out    = r_out_r;
  assign bus.G_out    = g_out_r;
  assign bus.B_out    = b_out_r;
endmodule

// File: tb/tb_reflet_rect_fill.sv
// Directed self-checking bench for reflet_rect_fill (define RECT_OUTLINE_EN to add the outline test).
module tb_reflet_rect_fill;
  localparam int H  = 640;
  localparam int V  = 480;
  localparam int C  = 8;
  localparam int XW = $clog2(H);
  localparam int YW = $clog2(V);

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  reflet_rect_fill_if #(.h_size(H), .v_line(V), .color_depth(C)) bus ();
  reflet_rect_fill #(.h_size(H), .v_line(V), .color_depth(C)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_vec = 0;
  int n_bad = 0;
  int cap_h[$];
  int cap_v[$];
  int cap_r[$];
  int cap_g[$];
  int cap_b[$];
  int cap_first;
  int cap_done;
  int cap_busy_bad;

  task automatic issue(input int x0, input int y0, input int x1, input int y1,
                       input int r, input int g, input int b, input bit ol);
    @(negedge clk);
    bus.x0   = XW'(x0);
    bus.y0   = YW'(y0);
    bus.x1   = XW'(x1);
    bus.y1   = YW'(y1);
    bus.R_in = C'(r);
    bus.G_in = C'(g);
    bus.B_in = C'(b);
`ifdef RECT_OUTLINE_EN
    bus.outline = ol;
`endif
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  // Records writes cycle by cycle after an accepted start; cycle 1 is N+1.
  task automatic capture(input int budget, input int pulse_at);
    cap_h.delete(); cap_v.delete(); cap_r.delete(); cap_g.delete(); cap_b.delete();
    cap_first = 0; cap_done = 0; cap_busy_bad = 0;
    for (int c = 1; c <= budget; c++) begin
      @(negedge clk);
      if (bus.write_en === 1'b1) begin
        if (cap_first == 0) cap_first = c;
        cap_h.push_back(int'(bus.h_pixel));
        cap_v.push_back(int'(bus.v_pixel));
        cap_r.push_back(int'(bus.R_out));
        cap_g.push_back(int'(bus.G_out));
        cap_b.push_back(int'(bus.B_out));
        if (bus.busy !== 1'b1) cap_busy_bad++;
      end
      if (bus.done === 1'b1) begin
        cap_done = c;
        if (bus.busy !== 1'b0 || bus.write_en !== 1'b0) cap_busy_bad++;
        break;
      end
      if (c == pulse_at) begin
        bus.x0 = XW'(9); bus.x1 = XW'(0); bus.y0 = YW'(9); bus.y1 = YW'(0);
        bus.start = 1'b1;
      end else begin
        bus.start = 1'b0;
      end
    end
    bus.start = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_vec++;
    if ({bus.write_en, bus.busy, bus.done, bus.h_pixel, bus.v_pixel, bus.R_out, bus.G_out, bus.B_out} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: got we=%b busy=%b done=%b h=%0d v=%0d expected all 0",
               bus.write_en, bus.busy, bus.done, bus.h_pixel, bus.v_pixel);
    end
  endtask

  task automatic check_six(input string name);
    int eh[6] = '{2, 3, 4, 2, 3, 4};
    int ev[6] = '{1, 1, 1, 2, 2, 2};
    n_vec++;
    if (cap_h.size() !== 6) begin
      n_bad++; $display("FAIL %s_count: got %0d expected 6", name, cap_h.size());
    end
    for (int i = 0; i < 6 && i < cap_h.size(); i++) begin
      n_vec++;
      if (cap_h[i] !== eh[i] || cap_v[i] !== ev[i]) begin
        n_bad++;
        $display("FAIL %s_write%0d: got (%0d,%0d) expected (%0d,%0d)", name, i, cap_h[i], cap_v[i], eh[i], ev[i]);
      end
    end
    n_vec++;
    if (cap_first !== 1 || cap_done !== 7 || cap_busy_bad !== 0) begin
      n_bad++;
      $display("FAIL %s_timing: got first=%0d done=%0d busy_err=%0d expected 1 7 0", name, cap_first, cap_done, cap_busy_bad);
    end
  endtask

  task automatic test_basic();
    issue(2, 1, 4, 2, 8'h11, 8'h22, 8'h33, 1'b0);
    capture(30, 0);
    check_six("basic");
    n_vec++;
    if (cap_r.size() > 0 && (cap_r[0] !== 8'h11 || cap_g[0] !== 8'h22 || cap_b[0] !== 8'h33)) begin
      n_bad++; $display("FAIL basic_colour: got %0h %0h %0h expected 11 22 33", cap_r[0], cap_g[0], cap_b[0]);
    end
  endtask

  task automatic test_swapped();
    issue(4, 2, 2, 1, 8'h44, 8'h55, 8'h66, 1'b0);
    capture(30, 0);
    check_six("swapped");
  endtask

  task automatic test_corner();
    issue(639, 479, 639, 479, 8'hFF, 8'h00, 8'h80, 1'b0);
    capture(30, 0);
    n_vec++;
    if (cap_h.size() !== 1 || cap_done !== 2) begin
      n_bad++; $display("FAIL corner_count: got writes=%0d done=%0d expected 1 2", cap_h.size(), cap_done);
    end else begin
      n_vec++;
      if (cap_h[0] !== 639 || cap_v[0] !== 479 || cap_r[0] !== 255 || cap_g[0] !== 0 || cap_b[0] !== 128) begin
        n_bad++;
        $display("FAIL corner_write: got (%0d,%0d) %0h %0h %0h expected (639,479) ff 0 80",
                 cap_h[0], cap_v[0], cap_r[0], cap_g[0], cap_b[0]);
      end
    end
    n_vec++;
    if (bus.h_pixel !== 10'd639 || bus.v_pixel !== 9'd479 || bus.R_out !== 8'hFF || bus.B_out !== 8'h80) begin
      n_bad++; $display("FAIL corner_hold: got (%0d,%0d) R=%0h B=%0h expected (639,479) ff 80",
                        bus.h_pixel, bus.v_pixel, bus.R_out, bus.B_out);
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    n_vec++;
    if ({bus.write_en, bus.busy, bus.done, bus.h_pixel, bus.v_pixel, bus.R_out, bus.G_out, bus.B_out} !== '0) begin
      n_bad++; $display("FAIL idle_reset: got h=%0d v=%0d R=%0h expected all 0", bus.h_pixel, bus.v_pixel, bus.R_out);
    end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_clamp();
    issue(1000, 500, 1023, 511, 8'h01, 8'h02, 8'h03, 1'b0);
    capture(30, 0);
    n_vec++;
    if (cap_h.size() !== 1 || cap_done !== 2 || (cap_h.size() == 1 && (cap_h[0] !== 639 || cap_v[0] !== 479))) begin
      n_bad++; $display("FAIL clamp: got writes=%0d done=%0d expected one write at (639,479) done 2", cap_h.size(), cap_done);
    end
  endtask

  task automatic test_single_row_col();
    issue(9, 7, 5, 7, 8'h0A, 8'h0B, 8'h0C, 1'b0);
    capture(30, 0);
    n_vec++;
    if (cap_h.size() !== 5 || cap_done !== 6) begin
      n_bad++; $display("FAIL row_count: got writes=%0d done=%0d expected 5 6", cap_h.size(), cap_done);
    end
    for (int i = 0; i < cap_h.size(); i++) begin
      n_vec++;
      if (cap_h[i] !== 5 + i || cap_v[i] !== 7) begin
        n_bad++; $display("FAIL row_write%0d: got (%0d,%0d) expected (%0d,7)", i, cap_h[i], cap_v[i], 5 + i);
      end
    end
    issue(3, 2, 3, 0, 8'h0A, 8'h0B, 8'h0C, 1'b0);
    capture(30, 0);
    n_vec++;
    if (cap_h.size() !== 3 || cap_done !== 4) begin
      n_bad++; $display("FAIL col_count: got writes=%0d done=%0d expected 3 4", cap_h.size(), cap_done);
    end
    for (int i = 0; i < cap_h.size(); i++) begin
      n_vec++;
      if (cap_h[i] !== 3 || cap_v[i] !== i) begin
        n_bad++; $display("FAIL col_write%0d: got (%0d,%0d) expected (3,%0d)", i, cap_h[i], cap_v[i], i);
      end
    end
  endtask

  task automatic test_ignore_start();
    issue(0, 0, 3, 1, 8'h20, 8'h21, 8'h22, 1'b0);
    capture(40, 3);
    n_vec++;
    if (cap_h.size() !== 8 || cap_done !== 9) begin
      n_bad++; $display("FAIL ignore_count: got writes=%0d done=%0d expected 8 9", cap_h.size(), cap_done);
    end
    n_vec++;
    if (cap_h.size() == 8 && (cap_h[7] !== 3 || cap_v[7] !== 1)) begin
      n_bad++; $display("FAIL ignore_last: got (%0d,%0d) expected (3,1)", cap_h[7], cap_v[7]);
    end
    issue(1, 1, 1, 1, 8'h30, 8'h31, 8'h32, 1'b0);
    capture(30, 0);
    n_vec++;
    if (cap_h.size() !== 1 || cap_done !== 2 || (cap_h.size() == 1 && (cap_h[0] !== 1 || cap_v[0] !== 1))) begin
      n_bad++; $display("FAIL restart: got writes=%0d done=%0d expected one write at (1,1) done 2", cap_h.size(), cap_done);
    end
  endtask

  task automatic test_reset_mid_fill();
    int seen = 0;
    int stray = 0;
    issue(0, 0, 3, 3, 8'h40, 8'h41, 8'h42, 1'b0);
    for (int c = 0; c < 20 && seen < 3; c++) begin
      @(negedge clk);
      if (bus.write_en === 1'b1) seen++;
    end
    n_vec++;
    if (seen !== 3) begin
      n_bad++; $display("FAIL abort_prewrites: got %0d expected 3", seen);
    end
    reset = 1'b0;
    #1;
    n_vec++;
    if (bus.write_en !== 1'b0 || bus.busy !== 1'b0 || bus.h_pixel !== '0 || bus.R_out !== '0) begin
      n_bad++; $display("FAIL abort_outputs: got we=%b busy=%b h=%0d R=%0h expected 0 0 0 0",
                        bus.write_en, bus.busy, bus.h_pixel, bus.R_out);
    end
    @(negedge clk);
    reset = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (bus.done !== 1'b0 || bus.write_en !== 1'b0) stray++;
    end
    n_vec++;
    if (stray !== 0) begin
      n_bad++; $display("FAIL abort_no_done: got %0d stray cycles expected 0", stray);
    end
  endtask

`ifdef RECT_OUTLINE_EN
  task automatic test_outline();
    int eh[12] = '{0, 1, 2, 3, 0, 3, 0, 3, 0, 1, 2, 3};
    int ev[12] = '{0, 0, 0, 0, 1, 1, 2, 2, 3, 3, 3, 3};
    issue(0, 0, 3, 3, 8'h50, 8'h51, 8'h52, 1'b1);
    capture(40, 0);
    n_vec++;
    if (cap_h.size() !== 12 || cap_done !== 13) begin
      n_bad++; $display("FAIL outline_count: got writes=%0d done=%0d expected 12 13", cap_h.size(), cap_done);
    end
    for (int i = 0; i < 12 && i < cap_h.size(); i++) begin
      n_vec++;
      if (cap_h[i] !== eh[i] || cap_v[i] !== ev[i]) begin
        n_bad++; $display("FAIL outline_write%0d: got (%0d,%0d) expected (%0d,%0d)", i, cap_h[i], cap_v[i], eh[i], ev[i]);
      end
    end
  endtask
`endif

  initial begin
    reset     = 1'b0;
    bus.start = 1'b0;
    bus.x0 = '0; bus.x1 = '0; bus.y0 = '0; bus.y1 = '0;
    bus.R_in = '0; bus.G_in = '0; bus.B_in = '0;
`ifdef RECT_OUTLINE_EN
    bus.outline = 1'b0;
`endif
    repeat (3) @(negedge clk);
    test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    test_basic();
    test_swapped();
    test_corner();
    test_clamp();
    test_single_row_col();
    test_ignore_start();
    test_reset_mid_fill();
`ifdef RECT_OUTLINE_EN
    test_outline();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
